// File: rtl/targeting_pkg.sv
// Shared targeting/launcher types, encodings and default timing constants.
// Queued fire in cooldown is enabled with the PROTON_FIRE_QUEUE_EN macro.
package targeting_pkg;

    typedef enum logic [2:0] {
        L_READY    = 3'd0,
        L_CHARGE   = 3'd1,
        L_RELEASE  = 3'd2,
        L_COOLDOWN = 3'd3,
        L_EMPTY    = 3'd4
    } launcher_state_t;

    typedef enum logic [1:0] {
        SENS_NONE  = 2'd0,
        SENS_IR    = 2'd1,
        SENS_RADAR = 2'd2,
        SENS_LOCK  = 2'd3
    } sensor_code_t;

    typedef enum logic [1:0] {
        TGT_IDLE    = 2'd0,
        TGT_ACQUIRE = 2'd1,
        TGT_TRACK   = 2'd2,
        TGT_FIRE    = 2'd3
    } target_state_t;

    localparam int DEF_CHARGE_CYCLES   = 4;
    localparam int DEF_COOLDOWN_CYCLES = 8;
    localparam int DEF_MAX_AMMO        = 2;
    localparam int DEF_AMMO_W          = 4;
    localparam int TIMER_W             = 8;

    function automatic logic is_busy(input launcher_state_t s);
        return (s == L_CHARGE) || (s == L_RELEASE) || (s == L_COOLDOWN);
    endfunction

endpackage

// File: rtl/proton_launcher_ctrl_launch_timer.sv
// Loadable 8-bit down-counter shared by the charge and cooldown phases.
// Counting stops at zero; load has priority over enable.
module launch_timer
    import targeting_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               enable,
    output logic               zero
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && !zero) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/proton_launcher_ctrl.sv
// Proton launcher sequencer: charge, release, cooldown, ammo and reload.
// Define PROTON_FIRE_QUEUE_EN to queue one fire request during cooldown.
module proton_launcher_ctrl
    import targeting_pkg::*;
#(
    parameter int CHARGE_CYCLES   = DEF_CHARGE_CYCLES,
    parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
    parameter int MAX_AMMO        = DEF_MAX_AMMO,
    parameter int AMMO_W          = DEF_AMMO_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              proton_fire,
    input  logic              abort,
    input  logic              reload_req,
    output logic              reload_ack,
    output logic              torpedo_release,
    output logic              fire_rejected,
    output logic              launcher_busy,
    output logic              launcher_empty,
    output logic [AMMO_W-1:0] ammo_count
);

    localparam logic [TIMER_W-1:0] CHG_LD  = TIMER_W'(CHARGE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] COOL_LD = TIMER_W'(COOLDOWN_CYCLES - 1);
    localparam logic [AMMO_W-1:0]  FULL    = AMMO_W'(MAX_AMMO);

    launcher_state_t    r_state, w_next;
    logic [AMMO_W-1:0]  r_ammo, w_ammo;
    logic               r_ack, w_ack;
    logic               r_rej, w_rej;
    logic               r_rel, r_busy, r_empty;
    logic               w_ld, w_en, w_zero;
    logic [TIMER_W-1:0] w_ldv;
`ifdef PROTON_FIRE_QUEUE_EN
    logic               r_pend, w_pend, w_pend_after;
`endif

    launch_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (w_ld),
        .load_value (w_ldv),
        .enable     (w_en),
        .zero       (w_zero)
    );

    always_comb begin
        w_next = r_state;
        w_ammo = r_ammo;
        w_ack  = 1'b0;
        w_rej  = 1'b0;
        w_ld   = 1'b0;
        w_ldv  = '0;
        w_en   = 1'b0;
`ifdef PROTON_FIRE_QUEUE_EN
        w_pend       = r_pend;
        w_pend_after = r_pend;
`endif
        unique case (r_state)
            L_READY: begin
                if (proton_fire) begin
                    w_next = L_CHARGE;
                    w_ld   = 1'b1;
                    w_ldv  = CHG_LD;
                end else if (reload_req) begin
                    w_ammo = FULL;
                    w_ack  = 1'b1;
                end
            end
            L_CHARGE: begin
                w_rej = proton_fire;
                if (abort) begin
                    w_next = L_READY;
`ifdef PROTON_FIRE_QUEUE_EN
                    w_pend = 1'b0;
`endif
                end else if (w_zero) begin
                    w_next = L_RELEASE;
                    w_ammo = r_ammo - AMMO_W'(1);
                end else begin
                    w_en = 1'b1;
                end
            end
            L_RELEASE: begin
                w_rej  = proton_fire;
                w_next = L_COOLDOWN;
                w_ld   = 1'b1;
                w_ldv  = COOL_LD;
            end
            L_COOLDOWN: begin
`ifdef PROTON_FIRE_QUEUE_EN
                // abort drops any queued shot; a fire beside it is refused
                w_rej        = proton_fire && (r_pend || abort);
                w_pend_after = (r_pend || proton_fire) && !abort;
                w_pend       = w_pend_after;
`else
                w_rej = proton_fire;
`endif
                if (w_zero) begin
                    if (r_ammo == '0) begin
                        w_next = L_EMPTY;
`ifdef PROTON_FIRE_QUEUE_EN
                        w_rej  = w_rej || w_pend_after;
                        w_pend = 1'b0;
`endif
                    end else begin
                        w_next = L_READY;
`ifdef PROTON_FIRE_QUEUE_EN
                        w_pend = 1'b0;
                        if (w_pend_after) begin
                            w_next = L_CHARGE;
                            w_ld   = 1'b1;
                            w_ldv  = CHG_LD;
                        end
`endif
                    end
                end else begin
                    w_en = 1'b1;
                end
            end
            L_EMPTY: begin
                w_rej = proton_fire;
                if (reload_req) begin
                    w_next = L_READY;
                    w_ammo = FULL;
                    w_ack  = 1'b1;
                end
            end
            default: w_next = L_READY;
        endcase
    end

    // release strobe trails the RELEASE state so a reset there suppresses it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= L_READY;
            r_ammo  <= FULL;
            r_ack   <= 1'b0;
            r_rej   <= 1'b0;
            r_rel   <= 1'b0;
            r_busy  <= 1'b0;
            r_empty <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ammo  <= w_ammo;
            r_ack   <= w_ack;
            r_rej   <= w_rej;
            r_rel   <= (r_state == L_RELEASE);
            r_busy  <= is_busy(w_next);
            r_empty <= (w_next == L_EMPTY);
        end
    end

`ifdef PROTON_FIRE_QUEUE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_pend;
        end
    end
`endif

    assign reload_ack      = r_ack;
    assign torpedo_release = r_rel;
    assign fire_rejected   = r_rej;
    assign launcher_busy   = r_busy;
    assign launcher_empty  = r_empty;
    assign ammo_count      = r_ammo;

endmodule

// File: tb/tb_proton_launcher_ctrl.sv
// Bench for proton_launcher_ctrl: timeline reference model plus literal checks.
// Honors PROTON_FIRE_QUEUE_EN to follow the queued-fire behaviour.
module tb_proton_launcher_ctrl;

    localparam int C    = 4;
    localparam int CD   = 8;
    localparam int MAXA = 2;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          rst, proton_fire, abort, reload_req;
    logic          reload_ack, torpedo_release, fire_rejected;
    logic          launcher_busy, launcher_empty;
    logic [AW-1:0] ammo_count;

    proton_launcher_ctrl #(
        .CHARGE_CYCLES   (C),
        .COOLDOWN_CYCLES (CD),
        .MAX_AMMO        (MAXA),
        .AMMO_W          (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .proton_fire     (proton_fire),
        .abort           (abort),
        .reload_req      (reload_req),
        .reload_ack      (reload_ack),
        .torpedo_release (torpedo_release),
        .fire_rejected   (fire_rejected),
        .launcher_busy   (launcher_busy),
        .launcher_empty  (launcher_empty),
        .ammo_count      (ammo_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int k = 0;

    // model: launch timeline anchored at the edge that accepted the fire
    int m_s     = -1;
    int m_ammo  = MAXA;
    bit m_empty = 1'b0;
    bit m_pend  = 1'b0;
    bit e_rel, e_rej, e_ack;

    int rel_k, ack_k, busy_cnt;
    bit rel_seen, rej_seen;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at edge %0d",
                     n, act, exp, k);
        end
    endtask

    task automatic model_step();
        int j;
        e_rel = 1'b0;
        e_rej = 1'b0;
        e_ack = 1'b0;
        if (rst) begin
            m_s = -1; m_ammo = MAXA; m_empty = 1'b0; m_pend = 1'b0;
        end else if (m_s >= 0) begin
            j = k - 1 - m_s;
            e_rel = (j == C);
            if (j < C) begin
                if (proton_fire) e_rej = 1'b1;
                if (abort) begin
                    m_s = -1; m_pend = 1'b0;
                end else if (j == C - 1) begin
                    m_ammo--;
                end
            end else if (j == C) begin
                if (proton_fire) e_rej = 1'b1;
            end else begin
`ifdef PROTON_FIRE_QUEUE_EN
                if (proton_fire) begin
                    if (m_pend || abort) e_rej = 1'b1;
                    else m_pend = 1'b1;
                end
                if (abort) m_pend = 1'b0;
`else
                if (proton_fire) e_rej = 1'b1;
`endif
                if (j == C + CD) begin
                    m_s = -1;
                    if (m_ammo == 0) begin
                        m_empty = 1'b1;
                        if (m_pend) e_rej = 1'b1;
                    end else if (m_pend) begin
                        m_s = k;
                    end
                    m_pend = 1'b0;
                end
            end
        end else if (m_empty) begin
            if (proton_fire) e_rej = 1'b1;
            if (reload_req) begin
                m_empty = 1'b0; m_ammo = MAXA; e_ack = 1'b1;
            end
        end else begin
            if (proton_fire) m_s = k;
            else if (reload_req) begin
                m_ammo = MAXA; e_ack = 1'b1;
            end
        end
    endtask

    task automatic cyc(input bit f, input bit a, input bit r, input bit rs);
        proton_fire = f; abort = a; reload_req = r; rst = rs;
        @(posedge clk);
        model_step();
        #1;
        chk("release", torpedo_release, e_rel);
        chk("rejected", fire_rejected, e_rej);
        chk("reload_ack", reload_ack, e_ack);
        chk("busy", launcher_busy, (m_s >= 0));
        chk("empty", launcher_empty, m_empty);
        chk("ammo", ammo_count, m_ammo);
        if (torpedo_release) begin rel_k = k; rel_seen = 1'b1; end
        if (reload_ack) ack_k = k;
        if (fire_rejected) rej_seen = 1'b1;
        if (launcher_busy) busy_cnt++;
        k++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    int s;

    initial begin
        proton_fire = 0; abort = 0; reload_req = 0; rst = 1;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("rst_ammo", ammo_count, 2);
        chk("rst_busy", launcher_busy, 0);
        idle(3);

        // single shot: latency, busy span, ammo step
        busy_cnt = 0; rel_seen = 0; s = k;
        cyc(1, 0, 0, 0);
        idle(16);
        chk("lat_release", rel_k - s, C + 1);
        chk("busy_span", busy_cnt, 13);
        chk("ammo_after1", ammo_count, 1);

        // drain to empty, then a refused fire
        cyc(1, 0, 0, 0);
        idle(16);
        chk("ammo_after2", ammo_count, 0);
        chk("empty_flag", launcher_empty, 1);
        rel_seen = 0; rej_seen = 0;
        cyc(1, 0, 0, 0);
        idle(3);
        chk("empty_rej", rej_seen, 1);
        chk("empty_norel", rel_seen, 0);

        // reload from empty
        cyc(0, 0, 1, 0);
        chk("reload_ack", reload_ack, 1);
        chk("reload_ammo", ammo_count, 2);
        chk("reload_ready", launcher_empty, 0);

        // abort on 2nd charge cycle
        rel_seen = 0; rej_seen = 0;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        idle(10);
        chk("abort_norel", rel_seen, 0);
        chk("abort_norej", rej_seen, 0);
        chk("abort_ammo", ammo_count, 2);

        // fire with held reload: ack only after the launch completes
        s = k; ack_k = -1;
        cyc(1, 0, 1, 0);
        for (int i = 0; i < 14; i++) cyc(0, 0, 1, 0);
        chk("late_ack", ack_k - s, 14);
        chk("late_ammo", ammo_count, 2);
        idle(2);

        // fire during RELEASE is refused
        cyc(1, 0, 0, 0);
        idle(4);
        cyc(1, 0, 0, 0);
        chk("rel_rej", fire_rejected, 1);
        idle(12);

        // reset while in RELEASE
        cyc(0, 0, 1, 0);
        rel_seen = 0;
        cyc(1, 0, 0, 0);
        idle(4);
        cyc(0, 0, 0, 1);
        chk("rstrel_rel", torpedo_release, 0);
        chk("rstrel_busy", launcher_busy, 0);
        chk("rstrel_ammo", ammo_count, 2);
        idle(2);
        chk("rstrel_norel", rel_seen, 0);

`ifdef PROTON_FIRE_QUEUE_EN
        rej_seen = 0;
        s = k;
        cyc(1, 0, 0, 0);
        idle(7);
        cyc(1, 0, 0, 0);
        idle(22);
        chk("q_norej", rej_seen, 0);
        chk("q_second_rel", rel_k - s, 13 + C + 1);
        cyc(0, 0, 1, 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 6) == 0, ($urandom % 20) == 0,
                ($urandom % 8) == 0, ($urandom % 200) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
